// File: rtl/set_bit_scanner_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | set_bit_scanner_if                                                      |
// | Vector-in / index-out handshake bundle for the set-bit scanner.         |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
interface set_bit_scanner_if #(
    parameter int WIDTH = 8
);
    localparam int IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic             in_valid_i;
    logic             in_ready_o;
    logic [WIDTH-1:0] A;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [IDXW-1:0]  idx_o;
    logic             last_o;
    logic             empty_o;

    // Scanner side
    modport slave (
        input  in_valid_i, A, out_ready_i,
        output in_ready_o, out_valid_o, idx_o, last_o, empty_o
    );

    // Producer/consumer side
    modport master (
        output in_valid_i, A, out_ready_i,
        input  in_ready_o, out_valid_o, idx_o, last_o, empty_o
    );
endinterface
`default_nettype wire

// File: rtl/set_bit_scanner.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | set_bit_scanner                                                         |
// | Emits the index of every set bit of an accepted vector, LSB first.      |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
module set_bit_scanner #(
    parameter int WIDTH = 8
) (
    input  wire logic          clk_i,
    input  wire logic          rst_ni,
    set_bit_scanner_if.slave   bus
);
    localparam int IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             zflag_q, zflag_d;

    logic [IDXW-1:0]  low_idx;
    logic [WIDTH-1:0] res_cleared;
    logic             res_last;
    logic             out_hs;
    logic             in_ready;

    // Highest index iterated first so the lowest set bit wins.
    always_comb begin
        low_idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (res_q[i]) begin
                low_idx = IDXW'(i);
            end
        end
    end

    assign res_cleared = res_q & (res_q - WIDTH'(1));
    assign res_last    = (res_cleared == '0);

    always_comb begin
        state_d  = state_q;
        res_d    = res_q;
        zflag_d  = zflag_q;
        in_ready = 1'b0;
        out_hs   = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid_i) begin
                    res_d   = bus.A;
                    zflag_d = (bus.A == '0);
                    state_d = SCAN;
                end
            end
            SCAN: begin
                out_hs = bus.out_ready_i;
                if (out_hs && !res_last) begin
                    res_d = res_cleared;
                end else if (out_hs) begin
                    // Last beat hands off straight to the next vector.
                    in_ready = 1'b1;
                    if (bus.in_valid_i) begin
                        res_d   = bus.A;
                        zflag_d = (bus.A == '0);
                    end else begin
                        res_d   = '0;
                        zflag_d = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            res_q   <= '0;
            zflag_q <= 1'b0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            zflag_q <= zflag_d;
        end
    end

    assign bus.in_ready_o  = in_ready;
    assign bus.out_valid_o = (state_q == SCAN);
    assign bus.idx_o       = ((state_q == SCAN) && !zflag_q) ? low_idx : '0;
    assign bus.last_o      = (state_q == SCAN) && res_last;
    assign bus.empty_o     = (state_q == SCAN) && zflag_q;

endmodule
`default_nettype wire

// File: doc/set_bit_scanner.md
# set_bit_scanner

Sequential set-bit enumerator: accepts a `width`-bit vector over a valid/ready handshake and emits the index of every set bit, one per cycle, from LSB to MSB. It is the expanding counterpart of the OR-reduction primitive in the arithmetic library. That primitive answers "is any bit set"; this block answers "which bits are set". It serves as a building block for request-list walkers and sparse-vector iterators.

## Interface
- `width`, 8, input vector width; legal range 1..256.
- `idxw`, `$clog2(width)` with a minimum of 1, index width; derived, never overridden.
- `clk_i` in 1 — clock; all state updates on rising edge.
- `rst_ni` in 1 — reset; asynchronous, active-low.
- `in_valid_i` in 1 — input vector valid.
- `in_ready_o` out 1 — block can accept a vector.
- `A` in `width` — input vector; sampled only on input handshake.
- `out_valid_o` out 1 — index beat valid.
- `out_ready_i` in 1 — downstream accepts beat.
- `idx_o` out `idxw` — index of lowest remaining set bit.
- `last_o` out 1 — current beat is the final beat for this vector.
- `empty_o` out 1 — accepted vector was all-zero (single beat).

## Operation
- The input handshake occurs when `in_valid_i` && `in_ready_o`. The output handshake occurs when `out_valid_o` && `out_ready_i`.
- State: two-state FSM (IDLE, SCAN), plus `res` (`width`-bit residual register) and `zflag` (1 bit).
- IDLE:
  - `in_ready_o` = 1; `out_valid_o` = 0.
  - On input handshake: `res` ← `A`; `zflag` ← (`A` == 0); go to SCAN.
- SCAN:
  - `out_valid_o` = 1.
  - `idx_o` = position of the lowest 1 in `res`. If `zflag` is set, `idx_o` = 0.
  - `last_o` = 1 when `res` has at most one bit set.
  - `empty_o` = `zflag`.
- SCAN, output handshake with `last_o` = 0: clear the lowest set bit of `res` (`res` ← `res` & (`res` − 1)); stay in SCAN.
- SCAN, output handshake with `last_o` = 1: the scan completes.
  - If `in_valid_i` is also high, the next vector is accepted in the same cycle. `in_ready_o` = 1 here, giving zero-bubble back-to-back operation. `res` and `zflag` load from `A`; stay in SCAN.
  - Otherwise go to IDLE.
- Elsewhere in SCAN, `in_ready_o` = 0.
- All-zero input produces exactly one beat: `idx_o` = 0, `last_o` = 1, `empty_o` = 1.
- While `out_valid_o` = 1 and `out_ready_i` = 0, `idx_o`, `last_o` and `empty_o` hold stable. `out_valid_o` never deasserts without a handshake.
- Indices are strictly increasing within one vector. Beat count = popcount(`A`), or 1 if `A` == 0.

## Timing
- Reset values (asynchronous, while `rst_ni` = 0):
  - FSM = IDLE, `res` = 0, `zflag` = 0.
  - Outputs: `out_valid_o` = 0, `idx_o` = 0, `last_o` = 0, `empty_o` = 0.
  - `in_ready_o` = 1 once `rst_ni` = 1.
- Latency: a vector accepted at edge N gives its first beat valid in the cycle after edge N. There is no combinational path from `A` or `in_valid_i` to any output.
- Throughput: one index per cycle when `out_ready_i` is held high. The worst case is `width` cycles per vector (all ones).
- `in_ready_o` has a combinational dependency on `out_ready_i` (last-beat handoff only). Downstream must not make `out_ready_i` depend on `in_ready_o`.
- `idx_o`, `last_o` and `empty_o` are decoded combinationally from registered `res`/`zflag`. The lowest-set-bit find is a priority encode over `width` bits.
- Reset mid-scan: the current vector is abandoned without a final beat. The first cycle after release is IDLE.
- `width` = 1: `idxw` = 1. Every vector produces exactly one beat with `idx_o` = 0; `empty_o` = ~`A`[0].

## Test plan
- Reset and idle, `width` = 8: hold `rst_ni` low, then release with `in_valid_i` = 0. Required: `out_valid_o` = 0, `in_ready_o` = 1, `idx_o` = 0 for 10 cycles.
- Sparse vector: `A` = 8'b1010_0100, `out_ready_i` = 1. Required: three beats, `idx_o` = 2, 5, 7. `last_o` = 1 only on idx 7; `empty_o` = 0 throughout; first beat one cycle after accept.
- Zero vector: `A` = 8'h00. Required: one beat with `idx_o` = 0, `last_o` = 1, `empty_o` = 1; then IDLE.
- Backpressure: `A` = 8'hFF, `out_ready_i` toggling 1,0,0,1,…. Required: idx sequence 0..7 with no skips or repeats; outputs stable while stalled; `in_ready_o` = 0 until the idx 7 handshake.
- Back-to-back: present `A` = 8'h81 and then `A` = 8'h10, with `in_valid_i` held high and `out_ready_i` = 1. Required: beats 0, 7(last), 4(last) on consecutive cycles, with zero bubbles.
- Reset mid-scan: accept 8'hF0, assert `rst_ni` = 0 after the first beat (idx 4). Required: outputs go to reset values immediately; after release, a new vector 8'h02 yields a single beat with idx 1.
